// File: rtl/stage_2_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : stage_2_sequencer
// Brief    : Owns the AV1 encoder range/low state, sequences one symbol at a
//            time through the stage-2 datapath and hands results to stage 3.
// Revision : 1.0 - initial release
// ============================================================================
module stage_2_sequencer #(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 24,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s1_valid,
    output logic                   s1_ready,
    input  logic [RANGE_WIDTH-1:0] s1_UU,
    input  logic [RANGE_WIDTH-1:0] s1_VV,
    input  logic [RANGE_WIDTH-1:0] s1_lut_u,
    input  logic [RANGE_WIDTH-1:0] s1_lut_v,
    input  logic                   s1_comp,
    input  logic                   flush,
    output logic [RANGE_WIDTH-1:0] dp_UU,
    output logic [RANGE_WIDTH-1:0] dp_VV,
    output logic [RANGE_WIDTH-1:0] dp_lut_u,
    output logic [RANGE_WIDTH-1:0] dp_lut_v,
    output logic                   dp_comp,
    output logic [RANGE_WIDTH-1:0] dp_in_range,
    output logic [LOW_WIDTH-1:0]   dp_in_low,
    input  logic [RANGE_WIDTH-1:0] dp_range,
    input  logic [LOW_WIDTH-1:0]   dp_low,
    output logic                   s3_valid,
    input  logic                   s3_ready,
    output logic [RANGE_WIDTH-1:0] s3_range,
    output logic [LOW_WIDTH-1:0]   s3_low,
    input  logic                   rn_valid,
    input  logic [RANGE_WIDTH-1:0] rn_range,
    input  logic [LOW_WIDTH-1:0]   rn_low,
    output logic [CNT_WIDTH-1:0]   sym_count,
    output logic                   flush_done,
    output logic                   protocol_err
);

    localparam logic [2:0] c_ST_READY   = 3'd0;
    localparam logic [2:0] c_ST_EXEC    = 3'd1;
    localparam logic [2:0] c_ST_SEND    = 3'd2;
    localparam logic [2:0] c_ST_WAIT_RN = 3'd3;
    localparam logic [2:0] c_ST_FLUSH   = 3'd4;

    localparam logic [RANGE_WIDTH-1:0] c_RANGE_INIT = {1'b1, {(RANGE_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]   c_CNT_MAX    = {CNT_WIDTH{1'b1}};

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic [RANGE_WIDTH-1:0] r_range;
    logic [LOW_WIDTH-1:0]   r_low;
    logic [RANGE_WIDTH-1:0] r_dp_uu;
    logic [RANGE_WIDTH-1:0] r_dp_vv;
    logic [RANGE_WIDTH-1:0] r_dp_lut_u;
    logic [RANGE_WIDTH-1:0] r_dp_lut_v;
    logic                   r_dp_comp;
    logic                   r_s3_valid;
    logic [RANGE_WIDTH-1:0] r_s3_range;
    logic [LOW_WIDTH-1:0]   r_s3_low;
    logic [CNT_WIDTH-1:0]   r_sym_count;
    logic                   r_flush_pend;
    logic                   r_protocol_err;

    logic w_accept;
    logic w_capture;
    logic w_s3_fire;
    logic w_rn_take;
    logic w_in_flush;
    logic w_pend_set;
    logic w_err_set;

    assign w_accept   = (r_state == c_ST_READY) && s1_valid;
    assign w_capture  = (r_state == c_ST_EXEC);
    assign w_s3_fire  = (r_state == c_ST_SEND) && s3_ready;
    assign w_rn_take  = (r_state == c_ST_WAIT_RN) && rn_valid;
    assign w_in_flush = (r_state == c_ST_FLUSH);
    // A flush seen while a symbol is in flight (or arriving with one) is deferred.
    assign w_pend_set = flush && (r_state != c_ST_FLUSH) &&
                        ((r_state != c_ST_READY) || s1_valid);
    assign w_err_set  = (rn_valid && (r_state != c_ST_WAIT_RN)) ||
                        (w_capture && (dp_range == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_READY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_READY: begin
                if (s1_valid) begin
                    w_next_state = c_ST_EXEC;
                end else if (flush) begin
                    w_next_state = c_ST_FLUSH;
                end
            end
            c_ST_EXEC:  w_next_state = c_ST_SEND;
            c_ST_SEND: begin
                if (s3_ready) begin
                    w_next_state = c_ST_WAIT_RN;
                end
            end
            c_ST_WAIT_RN: begin
                if (rn_valid) begin
                    w_next_state = (r_flush_pend || flush) ? c_ST_FLUSH : c_ST_READY;
                end
            end
            c_ST_FLUSH: w_next_state = c_ST_READY;
            default:    w_next_state = c_ST_READY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_range        <= c_RANGE_INIT;
            r_low          <= '0;
            r_dp_uu        <= '0;
            r_dp_vv        <= '0;
            r_dp_lut_u     <= '0;
            r_dp_lut_v     <= '0;
            r_dp_comp      <= 1'b0;
            r_s3_valid     <= 1'b0;
            r_s3_range     <= '0;
            r_s3_low       <= '0;
            r_sym_count    <= '0;
            r_flush_pend   <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dp_uu    <= s1_UU;
                r_dp_vv    <= s1_VV;
                r_dp_lut_u <= s1_lut_u;
                r_dp_lut_v <= s1_lut_v;
                r_dp_comp  <= s1_comp;
            end
            if (w_capture) begin
                r_s3_range <= dp_range;
                r_s3_low   <= dp_low;
                r_s3_valid <= 1'b1;
            end else if (w_s3_fire) begin
                r_s3_valid <= 1'b0;
            end
            if (w_in_flush) begin
                r_range      <= c_RANGE_INIT;
                r_low        <= '0;
                r_sym_count  <= '0;
                r_flush_pend <= 1'b0;
            end else begin
                if (w_rn_take) begin
                    r_range <= rn_range;
                    r_low   <= rn_low;
                    if (r_sym_count != c_CNT_MAX) begin
                        r_sym_count <= r_sym_count + CNT_WIDTH'(1);
                    end
                end
                if (w_pend_set) begin
                    r_flush_pend <= 1'b1;
                end
            end
            if (w_err_set) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    assign s1_ready     = (r_state == c_ST_READY);
    assign flush_done   = w_in_flush;
    assign dp_UU        = r_dp_uu;
    assign dp_VV        = r_dp_vv;
    assign dp_lut_u     = r_dp_lut_u;
    assign dp_lut_v     = r_dp_lut_v;
    assign dp_comp      = r_dp_comp;
    assign dp_in_range  = r_range;
    assign dp_in_low    = r_low;
    assign s3_valid     = r_s3_valid;
    assign s3_range     = r_s3_range;
    assign s3_low       = r_s3_low;
    assign sym_count    = r_sym_count;
    assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_stage_2_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_stage_2_sequencer
// Brief    : Self-checking bench for stage_2_sequencer with a stand-in
//            stage-2 datapath and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_2_sequencer;

    logic        clk;
    logic        reset;
    logic        s1_valid;
    logic        s1_ready;
    logic [15:0] s1_UU, s1_VV, s1_lut_u, s1_lut_v;
    logic        s1_comp;
    logic        flush;
    logic [15:0] dp_UU, dp_VV, dp_lut_u, dp_lut_v;
    logic        dp_comp;
    logic [15:0] dp_in_range;
    logic [23:0] dp_in_low;
    logic [15:0] dp_range;
    logic [23:0] dp_low;
    logic        s3_valid;
    logic        s3_ready;
    logic [15:0] s3_range;
    logic [23:0] s3_low;
    logic        rn_valid;
    logic [15:0] rn_range;
    logic [23:0] rn_low;
    logic [15:0] sym_count;
    logic        flush_done;
    logic        protocol_err;

    stage_2_sequencer #(.RANGE_WIDTH(16), .LOW_WIDTH(24), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .s1_valid(s1_valid), .s1_ready(s1_ready),
        .s1_UU(s1_UU), .s1_VV(s1_VV), .s1_lut_u(s1_lut_u), .s1_lut_v(s1_lut_v),
        .s1_comp(s1_comp), .flush(flush),
        .dp_UU(dp_UU), .dp_VV(dp_VV), .dp_lut_u(dp_lut_u), .dp_lut_v(dp_lut_v),
        .dp_comp(dp_comp), .dp_in_range(dp_in_range), .dp_in_low(dp_in_low),
        .dp_range(dp_range), .dp_low(dp_low),
        .s3_valid(s3_valid), .s3_ready(s3_ready), .s3_range(s3_range), .s3_low(s3_low),
        .rn_valid(rn_valid), .rn_range(rn_range), .rn_low(rn_low),
        .sym_count(sym_count), .flush_done(flush_done), .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in stage-2 datapath: comp=1 narrows to the V interval, comp=0 to U.
    function automatic logic [15:0] range_fn(input logic [15:0] r, input logic [15:0] uu,
                                             input logic [15:0] vv, input logic [15:0] lu,
                                             input logic [15:0] lv, input logic comp);
        int unsigned p;
        p = ((32'(r) >> 8) * (comp ? 32'(vv) : 32'(uu))) >> 1;
        return 16'(p + 32'(comp ? lv : lu));
    endfunction

    function automatic logic [23:0] low_fn(input logic [15:0] r, input logic [23:0] l,
                                           input logic [15:0] uu, input logic [15:0] lu,
                                           input logic comp);
        int unsigned s;
        s = 32'(l) + 32'(r) - 32'(uu) - 32'(lu);
        return comp ? 24'(s) : l;
    endfunction

    always_comb begin
        dp_range = range_fn(dp_in_range, dp_UU, dp_VV, dp_lut_u, dp_lut_v, dp_comp);
        dp_low   = low_fn(dp_in_range, dp_in_low, dp_UU, dp_lut_u, dp_comp);
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural state as the bench expects it to be.
    logic [15:0] m_range;
    logic [23:0] m_low;
    logic [15:0] m_count;
    logic        m_pend;
    logic        m_err;

    typedef struct {
        logic [15:0] uu, vv, lu, lv;
        logic        comp;
        int          stall;
        logic [15:0] rnr;
        logic [23:0] rnl;
        logic [15:0] exp_range;
        logic [23:0] exp_low;
        logic [15:0] exp_count;
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_range = 16'h8000;
        m_low   = '0;
        m_count = '0;
        m_pend  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_s1_ready"},   32'(s1_ready), 32'd1);
        check({tag, "_range"},      32'(dp_in_range), 32'(m_range));
        check({tag, "_low"},        32'(dp_in_low), 32'(m_low));
        check({tag, "_count"},      32'(sym_count), 32'(m_count));
        check({tag, "_err"},        32'(protocol_err), 32'(m_err));
        check({tag, "_flush_done"}, 32'(flush_done), 32'd0);
    endtask

    task automatic run_symbol(input logic [15:0] uu, input logic [15:0] vv,
                              input logic [15:0] lu, input logic [15:0] lv,
                              input logic comp, input logic flush_with_s1,
                              input int stall, input int rn_wait, input int flush_at,
                              input logic [15:0] rnr, input logic [23:0] rnl,
                              output logic [15:0] got_r, output logic [23:0] got_l);
        logic [15:0] exp_r;
        logic [23:0] exp_l;
        exp_r = range_fn(m_range, uu, vv, lu, lv, comp);
        exp_l = low_fn(m_range, m_low, uu, lu, comp);
        if (exp_r == 16'h0) m_err = 1'b1;
        check("sym_s1_ready", 32'(s1_ready), 32'd1);
        s1_valid = 1'b1; s1_UU = uu; s1_VV = vv; s1_lut_u = lu; s1_lut_v = lv;
        s1_comp = comp; flush = flush_with_s1;
        tick();
        s1_valid = 1'b0; flush = 1'b0;
        if (flush_with_s1) m_pend = 1'b1;
        check("exec_s1_ready", 32'(s1_ready), 32'd0);
        check("exec_s3_valid", 32'(s3_valid), 32'd0);
        tick();
        check("lat_s3_valid", 32'(s3_valid), 32'd1);
        check("lat_s3_range", 32'(s3_range), 32'(exp_r));
        check("lat_s3_low",   32'(s3_low), 32'(exp_l));
        got_r = s3_range;
        got_l = s3_low;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_s3_valid", 32'(s3_valid), 32'd1);
            check("stall_s3_range", 32'(s3_range), 32'(exp_r));
            check("stall_s3_low",   32'(s3_low), 32'(exp_l));
            check("stall_s1_ready", 32'(s1_ready), 32'd0);
        end
        s3_ready = 1'b1;
        tick();
        s3_ready = 1'b0;
        check("post_s3_valid", 32'(s3_valid), 32'd0);
        for (int i = 0; i < rn_wait; i++) begin
            if (i == flush_at) flush = 1'b1;
            tick();
            flush = 1'b0;
            if (i == flush_at) m_pend = 1'b1;
            check("wait_s3_valid", 32'(s3_valid), 32'd0);
        end
        rn_valid = 1'b1; rn_range = rnr; rn_low = rnl;
        tick();
        rn_valid = 1'b0;
        m_range = rnr;
        m_low   = rnl;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        if (m_pend) begin
            check("pend_flush_done", 32'(flush_done), 32'd1);
            check("pend_s1_ready", 32'(s1_ready), 32'd0);
            tick();
            model_reset();
        end
        check_state("sym");
    endtask

    task automatic flush_idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("idle_flush_done", 32'(flush_done), 32'd1);
        check("idle_flush_s1_ready", 32'(s1_ready), 32'd0);
        tick();
        model_reset();
        check_state("idle_flush");
    endtask

    task automatic rn_in_ready(input logic [15:0] rnr, input logic [23:0] rnl);
        rn_valid = 1'b1; rn_range = rnr; rn_low = rnl;
        tick();
        rn_valid = 1'b0;
        m_err = 1'b1;
        check_state("stray_rn");
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        tick();
        reset = 1'b1;
        model_reset();
        m_err = 1'b0;
        tick();
    endtask

    initial begin
        logic [15:0] gr;
        logic [23:0] gl;
        int          op, rw, fa;

        vecs[0] = '{16'h0040, 16'h0020, 16'h0004, 16'h0002, 1'b1, 5,
                    16'h9A00, 24'h000123, 16'h0802, 24'h007FBC, 16'd1};
        vecs[1] = '{16'h0010, 16'h0300, 16'h0001, 16'h0007, 1'b0, 0,
                    16'hC000, 24'hFFFFF0, 16'h04D1, 24'h000123, 16'd2};
        vecs[2] = '{16'h0100, 16'h0008, 16'h0010, 16'h0003, 1'b1, 2,
                    16'h8001, 24'h7FFFFF, 16'h0303, 24'h00BEE0, 16'd3};

        reset = 1'b0; s1_valid = 1'b0; s1_UU = '0; s1_VV = '0; s1_lut_u = '0;
        s1_lut_v = '0; s1_comp = 1'b0; flush = 1'b0; s3_ready = 1'b0;
        rn_valid = 1'b0; rn_range = '0; rn_low = '0;
        model_reset();
        m_err = 1'b0;
        tick();
        tick();
        check("rst_s1_ready", 32'(s1_ready), 32'd1);
        check("rst_range",    32'(dp_in_range), 32'h8000);
        check("rst_low",      32'(dp_in_low), 32'd0);
        check("rst_s3_valid", 32'(s3_valid), 32'd0);
        check("rst_count",    32'(sym_count), 32'd0);
        check("rst_dp_uu",    32'(dp_UU), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            run_symbol(vecs[i].uu, vecs[i].vv, vecs[i].lu, vecs[i].lv, vecs[i].comp, 1'b0,
                       vecs[i].stall, 1, -1, vecs[i].rnr, vecs[i].rnl, gr, gl);
            check("tbl_s3_range", 32'(gr), 32'(vecs[i].exp_range));
            check("tbl_s3_low",   32'(gl), 32'(vecs[i].exp_low));
            check("tbl_range",    32'(dp_in_range), 32'(vecs[i].rnr));
            check("tbl_low",      32'(dp_in_low), 32'(vecs[i].rnl));
            check("tbl_count",    32'(sym_count), 32'(vecs[i].exp_count));
        end

        // Flush alongside s1_valid: the symbol completes first, then the flush.
        run_symbol(16'h0020, 16'h0010, 16'h0002, 16'h0001, 1'b1, 1'b1, 0, 0, -1,
                   16'hA000, 24'h000055, gr, gl);
        check("flush_s1_range", 32'(dp_in_range), 32'h8000);
        check("flush_s1_count", 32'(sym_count), 32'd0);
        // Flush during WAIT_RN, then a back-to-back minimum-interval symbol.
        run_symbol(16'h0030, 16'h0040, 16'h0001, 16'h0005, 1'b0, 1'b0, 0, 2, 1,
                   16'hB000, 24'h000777, gr, gl);
        run_symbol(16'h0030, 16'h0040, 16'h0001, 16'h0005, 1'b1, 1'b0, 0, 0, -1,
                   16'hB000, 24'h000777, gr, gl);
        flush_idle();

        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 9);
            if (op == 0) begin
                flush_idle();
            end else if (op == 1) begin
                rn_in_ready(16'($urandom), 24'($urandom));
            end else begin
                rw = $urandom_range(0, 3);
                fa = (rw > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, rw - 1) : -1;
                run_symbol(16'($urandom), 16'($urandom), 16'($urandom_range(0, 255)),
                           16'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 5) == 0,
                           $urandom_range(0, 3), rw, fa, 16'($urandom_range(1, 65535)),
                           24'($urandom), gr, gl);
            end
        end

        do_reset();
        check("err_clear", 32'(protocol_err), 32'd0);
        rn_in_ready(16'h1234, 24'h000042);

        do_reset();
        check("err_clear2", 32'(protocol_err), 32'd0);
        run_symbol(16'h0040, 16'h0000, 16'h0004, 16'h0000, 1'b1, 1'b0, 0, 0, -1,
                   16'h9000, 24'h000010, gr, gl);
        check("zero_range_err", 32'(protocol_err), 32'd1);

        // Asynchronous reset while parked in WAIT_RN.
        s1_valid = 1'b1; s1_UU = 16'h0040; s1_VV = 16'h0020; s1_lut_u = 16'h4;
        s1_lut_v = 16'h2; s1_comp = 1'b1;
        tick();
        s1_valid = 1'b0;
        tick();
        s3_ready = 1'b1;
        tick();
        s3_ready = 1'b0;
        check("wrn_s1_ready", 32'(s1_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_s1_ready", 32'(s1_ready), 32'd1);
        check("arst_range",    32'(dp_in_range), 32'h8000);
        check("arst_low",      32'(dp_in_low), 32'd0);
        check("arst_count",    32'(sym_count), 32'd0);
        check("arst_err",      32'(protocol_err), 32'd0);
        check("arst_s3_range", 32'(s3_range), 32'd0);
        check("arst_s3_low",   32'(s3_low), 32'd0);
        check("arst_dp_uu",    32'(dp_UU), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
